// File: rtl/payload_engine_pkg.sv
// Shared types and constants for the payload character feeder.
// Case folding is only used when PAYLOAD_NOCASE_EN is defined.
package payload_engine_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SOD   = 3'd1,
        ST_DATA  = 3'd2,
        ST_FLUSH = 3'd3,
        ST_EOD   = 3'd4
    } feeder_state_t;

    typedef struct packed {
        logic [7:0] chr;
        logic       nocase;
    } class_entry_t;

    localparam logic [7:0] ASCII_UPPER_A  = 8'h41;
    localparam logic [7:0] ASCII_UPPER_Z  = 8'h5A;
    localparam logic [7:0] ASCII_CASE_BIT = 8'h20;

    // Maps A-Z onto a-z; every other byte passes through unchanged.
    function automatic logic [7:0] fold_case(input logic [7:0] b);
        if (b >= ASCII_UPPER_A && b <= ASCII_UPPER_Z) begin
            return b | ASCII_CASE_BIT;
        end
        return b;
    endfunction

endpackage

// File: rtl/payload_char_class.sv
// Programmable character-class table with a registered byte-to-class compare.
// PAYLOAD_NOCASE_EN adds a per-class case-insensitive flag.
module payload_char_class
    import payload_engine_pkg::*;
#(
    parameter int NUM_CLASSES = 48,
    parameter int ADDR_W      = 6
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   cfg_we_i,
    input  logic [ADDR_W-1:0]      cfg_addr_i,
    input  logic [7:0]             cfg_byte_i,
    input  logic                   cfg_nocase_i,
    input  logic [7:0]             byte_i,
    input  logic                   valid_i,
    output logic [NUM_CLASSES-1:0] cls_o
);

    logic [NUM_CLASSES-1:0] cls_q, cls_d;
    logic                   cfg_hit;

    assign cfg_hit = cfg_we_i && (int'(cfg_addr_i) < NUM_CLASSES);

`ifdef PAYLOAD_NOCASE_EN
    class_entry_t class_tab_q [NUM_CLASSES];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NUM_CLASSES; i++) class_tab_q[i] <= '0;
        end else if (cfg_hit) begin
            class_tab_q[cfg_addr_i] <= '{chr: cfg_byte_i, nocase: cfg_nocase_i};
        end
    end

    always_comb begin
        cls_d = '0;
        if (valid_i) begin
            for (int i = 0; i < NUM_CLASSES; i++) begin
                if (class_tab_q[i].nocase) begin
                    cls_d[i] = (fold_case(byte_i) == fold_case(class_tab_q[i].chr));
                end else begin
                    cls_d[i] = (byte_i == class_tab_q[i].chr);
                end
            end
        end
    end
`else
    logic [7:0] class_tab_q [NUM_CLASSES];
    logic       unused_nocase;

    assign unused_nocase = cfg_nocase_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NUM_CLASSES; i++) class_tab_q[i] <= '0;
        end else if (cfg_hit) begin
            class_tab_q[cfg_addr_i] <= cfg_byte_i;
        end
    end

    always_comb begin
        cls_d = '0;
        if (valid_i) begin
            for (int i = 0; i < NUM_CLASSES; i++) begin
                cls_d[i] = (byte_i == class_tab_q[i]);
            end
        end
    end
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) cls_q <= '0;
        else       cls_q <= cls_d;
    end

    assign cls_o = cls_q;

endmodule

// File: rtl/payload_char_feeder.sv
// Serialises an AXI4-Stream payload to one byte per cycle and drives the class
// vector, en, sod and eod to the engine array. Optional macro: PAYLOAD_NOCASE_EN.
module payload_char_feeder
    import payload_engine_pkg::*;
#(
    parameter int DATA_WIDTH  = 64,
    parameter int NUM_CLASSES = 48
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [DATA_WIDTH-1:0]        s_tdata,
    input  logic [DATA_WIDTH/8-1:0]      s_tkeep,
    input  logic                         s_tlast,
    input  logic                         s_tvalid,
    output logic                         s_tready,
    input  logic                         cfg_we,
    input  logic [$clog2(NUM_CLASSES)-1:0] cfg_addr,
    input  logic [7:0]                   cfg_byte,
    input  logic                         cfg_nocase,
    output logic [NUM_CLASSES-1:0]       cls,
    output logic                         en,
    output logic                         sod,
    output logic                         eod
);

    localparam int LANES  = DATA_WIDTH / 8;
    localparam int IDX_W  = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int ADDR_W = $clog2(NUM_CLASSES);

    feeder_state_t         state_q, state_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [LANES-1:0]      keep_q, keep_d;
    logic                  last_q, last_d;
    logic                  have_q, have_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic                  ready_q, ready_d;
    logic                  en_q, en_d;
    logic                  sod_q, sod_d;
    logic                  eod_q, eod_d;
    logic                  accept;
    logic [7:0]            next_byte;
    logic                  next_valid;

    // tkeep is contiguous from lane 0, so the final lane is the one whose successor is empty.
    function automatic logic is_final_lane(input logic [LANES-1:0] keep, input logic [IDX_W-1:0] idx);
        logic r;
        r = 1'b1;
        for (int i = 0; i < LANES - 1; i++) begin
            if (int'(idx) == i && keep[i+1]) r = 1'b0;
        end
        return r;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            data_q  <= '0;
            keep_q  <= '0;
            last_q  <= 1'b0;
            have_q  <= 1'b0;
            idx_q   <= '0;
            ready_q <= 1'b0;
            en_q    <= 1'b0;
            sod_q   <= 1'b0;
            eod_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            keep_q  <= keep_d;
            last_q  <= last_d;
            have_q  <= have_d;
            idx_q   <= idx_d;
            ready_q <= ready_d;
            en_q    <= en_d;
            sod_q   <= sod_d;
            eod_q   <= eod_d;
        end
    end

    // have_q marks that byte idx_q of the buffered word is on the outputs this cycle.
    always_comb begin
        accept  = s_tvalid && ready_q;
        state_d = state_q;
        data_d  = data_q;
        keep_d  = keep_q;
        last_d  = last_q;
        have_d  = have_q;
        idx_d   = idx_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    data_d  = s_tdata;
                    keep_d  = s_tkeep;
                    last_d  = s_tlast;
                    have_d  = 1'b0;
                    idx_d   = '0;
                    state_d = ST_SOD;
                end
            end
            ST_SOD: begin
                have_d  = keep_q[0];
                idx_d   = '0;
                state_d = (!keep_q[0] && last_q) ? ST_FLUSH : ST_DATA;
            end
            ST_DATA: begin
                if (have_q && !is_final_lane(keep_q, idx_q)) begin
                    idx_d = idx_q + 1'b1;
                end else if (have_q && last_q) begin
                    have_d  = 1'b0;
                    state_d = ST_FLUSH;
                end else if (accept) begin
                    data_d = s_tdata;
                    keep_d = s_tkeep;
                    last_d = s_tlast;
                    idx_d  = '0;
                    have_d = s_tkeep[0];
                    if (!s_tkeep[0] && s_tlast) state_d = ST_FLUSH;
                end else begin
                    have_d = 1'b0;
                end
            end
            ST_FLUSH: state_d = ST_EOD;
            ST_EOD:   state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Outputs are computed from next-state values and registered, so they line up with state_q.
    always_comb begin
        next_valid = (state_d == ST_DATA) && have_d;
        sod_d      = (state_d == ST_SOD);
        eod_d      = (state_d == ST_EOD);
        en_d       = next_valid || (state_d == ST_FLUSH);
        ready_d    = (state_d == ST_IDLE) ||
                     ((state_d == ST_DATA) &&
                      (!have_d || (is_final_lane(keep_d, idx_d) && !last_d)));
        next_byte  = '0;
        for (int i = 0; i < LANES; i++) begin
            if (int'(idx_d) == i) next_byte = data_d[8*i +: 8];
        end
    end

    payload_char_class #(
        .NUM_CLASSES (NUM_CLASSES),
        .ADDR_W      (ADDR_W)
    ) u_char_class (
        .clk_i        (clk),
        .rst_i        (rst),
        .cfg_we_i     (cfg_we),
        .cfg_addr_i   (cfg_addr),
        .cfg_byte_i   (cfg_byte),
        .cfg_nocase_i (cfg_nocase),
        .byte_i       (next_byte),
        .valid_i      (next_valid),
        .cls_o        (cls)
    );

    assign s_tready = ready_q;
    assign en       = en_q;
    assign sod      = sod_q;
    assign eod      = eod_q;

endmodule

// File: tb/tb_payload_char_feeder.sv
// Directed bench for payload_char_feeder: timing, class decode, back-to-back,
// reset mid-packet, empty last word and table-write latency.
module tb_payload_char_feeder;

    localparam int DW = 64;
    localparam int NC = 48;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [DW-1:0]   s_tdata = '0;
    logic [DW/8-1:0] s_tkeep = '0;
    logic            s_tlast = 1'b0;
    logic            s_tvalid = 1'b0;
    logic            s_tready;
    logic            cfg_we = 1'b0;
    logic [5:0]      cfg_addr = '0;
    logic [7:0]      cfg_byte = '0;
    logic            cfg_nocase = 1'b0;
    logic [NC-1:0]   cls;
    logic            en, sod, eod;

    int checks = 0;
    int errors = 0;

    payload_char_feeder #(.DATA_WIDTH(DW), .NUM_CLASSES(NC)) dut (
        .clk        (clk),
        .rst        (rst),
        .s_tdata    (s_tdata),
        .s_tkeep    (s_tkeep),
        .s_tlast    (s_tlast),
        .s_tvalid   (s_tvalid),
        .s_tready   (s_tready),
        .cfg_we     (cfg_we),
        .cfg_addr   (cfg_addr),
        .cfg_byte   (cfg_byte),
        .cfg_nocase (cfg_nocase),
        .cls        (cls),
        .en         (en),
        .sod        (sod),
        .eod        (eod)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cfg_write(input logic [5:0] addr, input logic [7:0] b, input logic nc);
        cfg_we = 1'b1; cfg_addr = addr; cfg_byte = b; cfg_nocase = nc;
        tick();
        cfg_we = 1'b0;
    endtask

    // Offers one word and returns in the cycle after it was accepted (A+1).
    task automatic send_word(input string tag, input logic [DW-1:0] d,
                             input logic [DW/8-1:0] k, input logic l);
        int n;
        s_tdata = d; s_tkeep = k; s_tlast = l; s_tvalid = 1'b1;
        n = 0;
        while (!s_tready && n < 40) begin tick(); n++; end
        chk({tag, "_ready"}, {63'd0, s_tready}, 64'd1);
        tick();
        s_tvalid = 1'b0;
    endtask

    task automatic chk_out(input string tag, input logic e_sod, input logic e_en,
                           input logic e_eod, input logic [NC-1:0] e_cls);
        chk({tag, "_sod"}, {63'd0, sod}, {63'd0, e_sod});
        chk({tag, "_en"},  {63'd0, en},  {63'd0, e_en});
        chk({tag, "_eod"}, {63'd0, eod}, {63'd0, e_eod});
        chk({tag, "_cls"}, {16'd0, cls}, {16'd0, e_cls});
    endtask

    initial begin
        int en_cnt;
        int sod_at;
        int eod_at;
        int overlap;
        int eod_seen;
        logic [NC-1:0] exp_c;

        // reset
        tick(); tick();
        chk("rst_ready", {63'd0, s_tready}, 64'd0);
        chk_out("rst", 1'b0, 1'b0, 1'b0, '0);
        rst = 1'b0;
        tick();
        chk("idle_ready", {63'd0, s_tready}, 64'd1);

        // exact and case-insensitive match: "/Tt"
        cfg_write(6'd0, 8'h2F, 1'b0);
        cfg_write(6'd1, 8'h74, 1'b1);
        send_word("p1", 64'h0000_0000_0074_542F, 8'h07, 1'b1);
        chk_out("p1_a1", 1'b1, 1'b0, 1'b0, '0);
        tick(); chk_out("p1_a2", 1'b0, 1'b1, 1'b0, 48'h1);
`ifdef PAYLOAD_NOCASE_EN
        tick(); chk_out("p1_a3", 1'b0, 1'b1, 1'b0, 48'h2);
`else
        tick(); chk_out("p1_a3", 1'b0, 1'b1, 1'b0, 48'h0);
`endif
        tick(); chk_out("p1_a4", 1'b0, 1'b1, 1'b0, 48'h2);
        tick(); chk_out("p1_a5", 1'b0, 1'b1, 1'b0, '0);
        tick(); chk_out("p1_a6", 1'b0, 1'b0, 1'b1, '0);
        tick(); chk_out("p1_a7", 1'b0, 1'b0, 1'b0, '0);
        chk("p1_a7_ready", {63'd0, s_tready}, 64'd1);

        // multi-word: "abcdefgh" then "xyz" with tvalid held
        cfg_write(6'd2, 8'h63, 1'b0);
        cfg_write(6'd3, 8'h79, 1'b0);
        send_word("p2", 64'h6867_6665_6463_6261, 8'hFF, 1'b0);
        s_tdata = 64'h0000_0000_007A_7978; s_tkeep = 8'h07; s_tlast = 1'b1; s_tvalid = 1'b1;
        chk("p2_sod", {63'd0, sod}, 64'd1);
        en_cnt = 0;
        for (int k = 0; k < 11; k++) begin
            if (s_tvalid && s_tready) begin tick(); s_tvalid = 1'b0; end
            else tick();
            if (en) en_cnt++;
            exp_c = (k == 2) ? 48'h4 : (k == 9) ? 48'h8 : 48'h0;
            chk($sformatf("p2_cls%0d", k), {16'd0, cls}, {16'd0, exp_c});
        end
        chk("p2_en_run", 64'(en_cnt), 64'd11);
        chk("p2_tvalid_taken", {63'd0, s_tvalid}, 64'd0);
        tick(); chk_out("p2_flush", 1'b0, 1'b1, 1'b0, '0);
        tick(); chk_out("p2_eod", 1'b0, 1'b0, 1'b1, '0);

        // back-to-back: second packet offered in the eod cycle
        tick();
        send_word("p3", 64'h63, 8'h01, 1'b1);
        tick(); chk_out("p3_byte", 1'b0, 1'b1, 1'b0, 48'h4);
        tick(); chk_out("p3_flush", 1'b0, 1'b1, 1'b0, '0);
        tick(); chk_out("p3_eod", 1'b0, 1'b0, 1'b1, '0);
        s_tdata = 64'h79; s_tkeep = 8'h01; s_tlast = 1'b1; s_tvalid = 1'b1;
        sod_at = -1; eod_at = -1; overlap = 0;
        for (int c = 1; c <= 8; c++) begin
            if (s_tvalid && s_tready) begin tick(); s_tvalid = 1'b0; end
            else tick();
            if (sod && sod_at < 0) sod_at = c;
            if (eod && eod_at < 0) eod_at = c;
            if (sod && (en || eod)) overlap++;
        end
        chk("p4_sod_gap_ge2", {63'd0, (sod_at >= 2)}, 64'd1);
        chk("p4_eod_after_sod", 64'(eod_at - sod_at), 64'd3);
        chk("p4_overlap", 64'(overlap), 64'd0);

        // reset mid-packet
        send_word("p5", 64'h6867_6665_6463_6261, 8'hFF, 1'b0);
        tick(); tick();
        chk("p5_in_data_en", {63'd0, en}, 64'd1);
        rst = 1'b1;
        #1;
        chk_out("p5_rst", 1'b0, 1'b0, 1'b0, '0);
        chk("p5_rst_ready", {63'd0, s_tready}, 64'd0);
        eod_seen = 0;
        tick(); if (eod) eod_seen++;
        tick(); if (eod) eod_seen++;
        rst = 1'b0;
        tick(); if (eod) eod_seen++;
        chk("p5_no_eod", 64'(eod_seen), 64'd0);
        chk("p5_ready", {63'd0, s_tready}, 64'd1);
        // cleared table: NUL hits every class, '/' hits none
        send_word("p6", 64'h2F00, 8'h03, 1'b1);
        chk_out("p6_sod", 1'b1, 1'b0, 1'b0, '0);
        tick(); chk_out("p6_nul", 1'b0, 1'b1, 1'b0, {NC{1'b1}});
        tick(); chk_out("p6_slash", 1'b0, 1'b1, 1'b0, '0);
        tick(); chk_out("p6_flush", 1'b0, 1'b1, 1'b0, '0);
        tick(); chk_out("p6_eod", 1'b0, 1'b0, 1'b1, '0);

        // empty last word
        tick();
        send_word("p7", 64'h0, 8'h00, 1'b1);
        chk_out("p7_sod", 1'b1, 1'b0, 1'b0, '0);
        tick(); chk_out("p7_flush", 1'b0, 1'b1, 1'b0, '0);
        tick(); chk_out("p7_eod", 1'b0, 1'b0, 1'b1, '0);
        tick(); chk_out("p7_idle", 1'b0, 1'b0, 1'b0, '0);

        // table write in cycle T reaches bytes emitted from T+2
        send_word("p8", 64'h71_7171, 8'h07, 1'b1);
        tick(); chk_out("p8_b0", 1'b0, 1'b1, 1'b0, '0);
        cfg_we = 1'b1; cfg_addr = 6'd4; cfg_byte = 8'h71; cfg_nocase = 1'b0;
        tick(); cfg_we = 1'b0;
        chk_out("p8_b1", 1'b0, 1'b1, 1'b0, '0);
        tick(); chk_out("p8_b2", 1'b0, 1'b1, 1'b0, 48'h10);
        tick(); chk_out("p8_flush", 1'b0, 1'b1, 1'b0, '0);
        tick(); chk_out("p8_eod", 1'b0, 1'b0, 1'b1, '0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/payload_char_feeder.md
# payload_char_feeder

Upstream driver for the payload matching engines. Accepts packet payload as an AXI4-Stream of DATA_WIDTH-bit words, serialises it to one byte per cycle, and decodes each byte against a programmable table of NUM_CLASSES character classes. The result is the one-hot class vector, the en strobe, the sod clear and an eod "results valid" pulse, all fanned out to every engine instance. One feeder sits in front of the whole engine array.

## Interface
- DATA_WIDTH, 64: stream word width; multiple of 8.
- NUM_CLASSES, 48: number of character classes driven to the engines.
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- s_tdata  in  DATA_WIDTH  payload word; lane 0 = bits [7:0] is the first byte.
- s_tkeep  in  DATA_WIDTH/8  byte-valid mask; contiguous from lane 0.
- s_tlast  in  1  last word of the packet.
- s_tvalid  in  1  word valid.
- s_tready  out  1  word accepted when s_tvalid && s_tready.
- cfg_we  in  1  class-table write strobe.
- cfg_addr  in  $clog2(NUM_CLASSES)  class index.
- cfg_byte  in  8  class byte value.
- cfg_nocase  in  1  class matches case-insensitively.
- cls  out  NUM_CLASSES  per-byte class hit vector; drives the engines' in_N inputs.
- en  out  1  engine clock enable.
- sod  out  1  start-of-data clear to the engines.
- eod  out  1  engine outputs are final for this packet.

## Operation
- FSM states: IDLE, SOD, DATA, FLUSH, EOD.
- IDLE:
  - s_tready=1.
  - On accepting a word, latch the word, its tkeep and tlast, then go to SOD.
- SOD: one cycle with sod=1, en=0, cls=0. Goes to DATA, or to FLUSH if the latched tkeep=0 and tlast=1.
- DATA: emits one valid byte per cycle with en=1 and cls[i] = (byte == table[i].byte).
  - With nocase set, the compare is done after ASCII case folding: A–Z and a–z are equal.
  - s_tready=1 in the cycle the word's last valid byte is emitted. A word accepted then supplies the next cycle's byte with no bubble.
  - After the last byte of a tlast word, go to FLUSH.
  - If no word is available, hold en=0 and stay in DATA.
  - A tkeep=0 word emits nothing.
- FLUSH: one cycle with en=1, cls=0. This lets each engine's end-state register latch its final term. Then go to EOD.
- EOD: one cycle with eod=1, en=0. Then go to IDLE.
- Class table: NUM_CLASSES entries of {byte, nocase}.
  - All entries reset to {0x00, 0}.
  - A write in cycle T affects bytes emitted from T+2 onward.
  - Writes are accepted in any state.
- A table entry with byte 0x00 still matches NUL bytes. Software must assign every class.

## Timing
- Reset values: s_tready=0 while rst is high, then 1 in IDLE. cls=0, en=0, sod=0, eod=0.
- All outputs are registered.
- Word accepted in cycle A:
  - sod in A+1.
  - byte k with en in A+2+k.
  - for a single-word packet of n bytes: FLUSH in A+2+n, eod in A+3+n.
- Engine match outputs are valid and stable throughout the eod cycle.
- sod never coincides with en or eod. The next sod is at least 2 cycles after eod, because the engine CLR is asynchronous.
- Reset mid-packet:
  - All state returns to IDLE and the partial packet is discarded.
  - No eod is produced for it.
  - The class table is also reset.

## Configuration
- PAYLOAD_NOCASE_EN defined: the cfg_nocase bit is stored and case folding is applied per class.
- PAYLOAD_NOCASE_EN undefined:
  - cfg_nocase is ignored and no storage is generated.
  - All compares are exact.

## Structure
- Package payload_engine_pkg holds:
  - the FSM state enum;
  - the class-entry struct {byte, nocase};
  - the ASCII case constants 'A', 'Z' and 0x20.
- One sub-module, payload_char_class:
  - holds the table and the registered byte-to-class-vector compare;
  - instantiated once by the FSM/serialiser top.

## Test plan
- Exact and case-insensitive match:
  - Stimulus: class0={0x2F,0}, class1={'t',1}; one word "/Tt", tkeep=0x07, tlast, accepted at A.
  - Response: sod A+1. en A+2..A+5. cls[0] in A+2. cls[1] in A+3 and A+4. cls=0 in A+5. eod A+6.
- Multi-word packet:
  - Stimulus: 8 bytes then 3 bytes (tkeep=0x07, tlast), tvalid held.
  - Response: 11 consecutive en cycles with no bubble, then one flush cycle and eod.
- Build without PAYLOAD_NOCASE_EN:
  - Stimulus: class1={'t',1}, byte 'T'.
  - Response: cls[1]=0; byte 't' gives cls[1]=1.
- Back-to-back packets:
  - Stimulus: second packet offered in the eod cycle.
  - Response: second sod no earlier than eod+2; en never high alongside sod.
- Reset mid-packet:
  - Stimulus: rst asserted during DATA.
  - Response: all outputs 0 immediately, no eod, table cleared. A following packet produces a clean sod/en/eod sequence.
- Empty last word:
  - Stimulus: tkeep=0, tlast.
  - Response: sod, FLUSH (en=1, cls=0), eod; no data bytes.
